external_interrupt_controller: RTL and testbench

EXTERNAL_INTERRUPT_CONTROLLER -- requirements
Module: external_interrupt_controller

---
 rtl/external_interrupt_controller.sv | 76 +++++++
 tb/tb_external_interrupt_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/external_interrupt_controller.sv
// external_interrupt_controller: synchronised edge-triggered IRQ sources with pending/enable registers and a four-phase request handshake.
module external_interrupt_controller #(
  parameter logic [29:0] BASE_ADDR   = 30'h0000_0100,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        Sys_Clock,
  input  logic        Sys_Reset,
  input  logic [1:0]  IRQ_Src,
  input  logic        IO_EnR,
  input  logic        IO_EnW,
  input  logic [29:0] IO_Address,
  input  logic [31:0] IO_DataW,
  output logic [31:0] IO_DataR,
  output logic        EIC_I_Req,
  output logic        EIC_I_Id,
  input  logic        EIC_I_Ack
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_REL} state_t;
  state_t      state;
  logic [1:0]  sync_q [SYNC_STAGES];
  logic [1:0]  prev_q, pend, en, edge_det, set_v, clr_v, act, off;
  logic [2:0]  settle;
  logic        settled, hit, wr_hit, unused_dataw;
  logic [31:0] rd_data;
  assign off          = IO_Address[1:0];
  assign hit          = IO_Address[29:2] == BASE_ADDR[29:2];
  assign wr_hit       = IO_EnW && hit;
  assign settled      = settle == 3'(SYNC_STAGES + 1);
  assign act          = pend & en;
  assign unused_dataw = ^IO_DataW[31:2];
  // Edges are masked until the chain has flushed and prev_q holds the settled level.
  always_comb begin
    edge_det = settled ? sync_q[SYNC_STAGES-1] & ~prev_q : 2'b00;
    set_v    = edge_det | (wr_hit && off == 2'd3 ? IO_DataW[1:0] : 2'b00);
    clr_v    = (wr_hit && off == 2'd2 ? IO_DataW[1:0] : 2'b00)
             | (state == REQ && EIC_I_Ack ? 2'b01 << EIC_I_Id : 2'b00);
    rd_data  = off == 2'd0 ? {28'b0, en, pend} : off == 2'd1 ? {30'b0, en} : 32'b0;
  end
  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= 2'b00;
      prev_q    <= 2'b00;
      settle    <= 3'd0;
      pend      <= 2'b00;
      en        <= 2'b00;
      IO_DataR  <= 32'b0;
      state     <= IDLE;
      EIC_I_Req <= 1'b0;
      EIC_I_Id  <= 1'b0;
    end else begin
      sync_q[0] <= IRQ_Src;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      settle <= settled ? settle : settle + 3'd1;
      pend   <= (pend & ~clr_v) | set_v;
      if (wr_hit && off == 2'd1) en <= IO_DataW[1:0];
      if (IO_EnR) IO_DataR <= hit ? rd_data : 32'b0;
      unique case (state)
        IDLE: if (act != 2'b00 && !EIC_I_Ack) begin
          state     <= REQ;
          EIC_I_Req <= 1'b1;
          EIC_I_Id  <= ~act[0];
        end
        REQ: if (EIC_I_Ack) begin
          state     <= WAIT_REL;
          EIC_I_Req <= 1'b0;
        end
        WAIT_REL: if (!EIC_I_Ack) state <= IDLE;
        default: begin
          state     <= IDLE;
          EIC_I_Req <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_external_interrupt_controller.sv
// tb_external_interrupt_controller: directed scoreboard bench for the interrupt controller.
module tb_external_interrupt_controller;
  localparam logic [29:0] BASE = 30'h0000_0100;
  localparam logic [29:0] MISS = 30'h0000_0055;
  logic        Sys_Clock, Sys_Reset, IO_EnR, IO_EnW, EIC_I_Req, EIC_I_Id, EIC_I_Ack;
  logic [1:0]  IRQ_Src;
  logic [29:0] IO_Address;
  logic [31:0] IO_DataW, IO_DataR;
  logic [31:0] sb [$];
  int checks = 0;
  int errors = 0;
  external_interrupt_controller dut (
    .Sys_Clock(Sys_Clock), .Sys_Reset(Sys_Reset), .IRQ_Src(IRQ_Src),
    .IO_EnR(IO_EnR), .IO_EnW(IO_EnW), .IO_Address(IO_Address),
    .IO_DataW(IO_DataW), .IO_DataR(IO_DataR), .EIC_I_Req(EIC_I_Req),
    .EIC_I_Id(EIC_I_Id), .EIC_I_Ack(EIC_I_Ack)
  );
  initial Sys_Clock = 1'b0;
  always #5 Sys_Clock = ~Sys_Clock;
  task automatic tick(input int n = 1);
    repeat (n) @(posedge Sys_Clock);
    #1;
  endtask
  task automatic cmp(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty obs=%h", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s obs=%h exp=%h", tag, obs, e);
      end
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    sb.push_back(e);
    cmp(tag, obs);
  endtask
  task automatic wr(input logic [1:0] o, input logic [31:0] d);
    IO_Address = BASE + 30'(o);
    IO_DataW   = d;
    IO_EnW     = 1'b1;
    tick();
    IO_EnW     = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [29:0] a, input logic [31:0] e);
    sb.push_back(e);
    IO_Address = a;
    IO_EnR     = 1'b1;
    tick();
    IO_EnR     = 1'b0;
    cmp(tag, IO_DataR);
  endtask
  task automatic ack_cycle();
    EIC_I_Ack = 1'b1;
    tick();
    EIC_I_Ack = 1'b0;
    tick();
  endtask
  initial begin
    Sys_Reset = 1'b0; IRQ_Src = 2'b00; IO_EnR = 1'b0; IO_EnW = 1'b0;
    IO_Address = '0; IO_DataW = '0; EIC_I_Ack = 1'b0;
    tick(3);
    chk("rst_req", EIC_I_Req, 0);
    chk("rst_id", EIC_I_Id, 0);
    chk("rst_datar", IO_DataR, 0);
    Sys_Reset = 1'b1;
    tick(4);
    rd("rst_status", BASE, 32'h0);
    // single source, latency and ack
    wr(2'd1, 32'h3);
    rd("en_read", BASE + 30'd1, 32'h3);
    IRQ_Src = 2'b10;
    tick();
    IRQ_Src = 2'b00;
    tick();
    chk("lat_n1", EIC_I_Req, 0);
    tick();
    chk("lat_n2", EIC_I_Req, 0);
    tick();
    chk("lat_n3_req", EIC_I_Req, 1);
    chk("lat_n3_id", EIC_I_Id, 1);
    EIC_I_Ack = 1'b1;
    tick();
    chk("ack_req_low", EIC_I_Req, 0);
    rd("status_after_ack", BASE, 32'hC);
    EIC_I_Ack = 1'b0;
    tick();
    // simultaneous sources, priority and idle gap
    IRQ_Src = 2'b11;
    tick();
    IRQ_Src = 2'b00;
    tick(3);
    chk("both_req", EIC_I_Req, 1);
    chk("both_id0", EIC_I_Id, 0);
    EIC_I_Ack = 1'b1;
    tick();
    chk("both_ack", EIC_I_Req, 0);
    EIC_I_Ack = 1'b0;
    tick();
    chk("idle_gap", EIC_I_Req, 0);
    tick();
    chk("second_req", EIC_I_Req, 1);
    chk("second_id1", EIC_I_Id, 1);
    ack_cycle();
    // disabled source stays pending until enabled
    wr(2'd1, 32'h0);
    IRQ_Src = 2'b01;
    tick();
    IRQ_Src = 2'b00;
    tick(4);
    chk("dis_no_req", EIC_I_Req, 0);
    rd("dis_status", BASE, 32'h1);
    wr(2'd1, 32'h1);
    tick();
    chk("en_late_req", EIC_I_Req, 1);
    chk("en_late_id", EIC_I_Id, 0);
    ack_cycle();
    // trigger wins over ack clear
    wr(2'd1, 32'h3);
    wr(2'd3, 32'h2);
    tick();
    chk("trig_req", EIC_I_Req, 1);
    chk("trig_id", EIC_I_Id, 1);
    IO_Address = BASE + 30'd3; IO_DataW = 32'h2; IO_EnW = 1'b1; EIC_I_Ack = 1'b1;
    tick();
    IO_EnW = 1'b0;
    chk("trig_ack_req", EIC_I_Req, 0);
    rd("trig_wins", BASE, 32'hE);
    EIC_I_Ack = 1'b0;
    tick(2);
    chk("trig_rereq", EIC_I_Req, 1);
    chk("trig_reid", EIC_I_Id, 1);
    ack_cycle();
    // request not withdrawn by software clear/disable
    wr(2'd3, 32'h1);
    tick();
    chk("hold_req", EIC_I_Req, 1);
    wr(2'd2, 32'h3);
    wr(2'd1, 32'h0);
    chk("hold_after_sw", EIC_I_Req, 1);
    chk("hold_id", EIC_I_Id, 0);
    EIC_I_Ack = 1'b1;
    tick();
    chk("hold_acked", EIC_I_Req, 0);
    EIC_I_Ack = 1'b0;
    tick();
    rd("clear_status", BASE, 32'h0);
    // ack in idle is ignored
    wr(2'd3, 32'h2);
    EIC_I_Ack = 1'b1;
    wr(2'd1, 32'h2);
    tick(2);
    chk("idle_ack_no_req", EIC_I_Req, 0);
    rd("idle_ack_status", BASE, 32'hA);
    EIC_I_Ack = 1'b0;
    tick();
    chk("idle_ack_req", EIC_I_Req, 1);
    chk("idle_ack_id", EIC_I_Id, 1);
    ack_cycle();
    // read path: hit, hold, miss, ignored writes
    wr(2'd3, 32'h1);
    rd("rd_hit", BASE, 32'h9);
    tick(2);
    chk("rd_hold", IO_DataR, 32'h9);
    rd("rd_miss", MISS, 32'h0);
    tick(2);
    chk("rd_miss_hold", IO_DataR, 32'h0);
    wr(2'd0, 32'hF);
    rd("status_ro", BASE, 32'h9);
    rd("trigger_reads0", BASE + 30'd3, 32'h0);
    wr(2'd2, 32'h1);
    rd("w1c", BASE, 32'h8);
    // async reset mid-handshake, source held high afterwards
    wr(2'd1, 32'h3);
    wr(2'd3, 32'h1);
    tick();
    chk("pre_rst_req", EIC_I_Req, 1);
    Sys_Reset = 1'b0;
    IRQ_Src = 2'b11;
    #1;
    chk("async_rst_req", EIC_I_Req, 0);
    chk("async_rst_datar", IO_DataR, 0);
    tick(2);
    Sys_Reset = 1'b1;
    tick(10);
    chk("held_high_no_req", EIC_I_Req, 0);
    rd("post_rst_status", BASE, 32'h0);
    wr(2'd1, 32'h3);
    tick(3);
    chk("held_high_en_no_req", EIC_I_Req, 0);
    rd("held_high_status", BASE, 32'hC);
    IRQ_Src = 2'b00;
    tick(3);
    IRQ_Src = 2'b01;
    tick(4);
    chk("retrigger_req", EIC_I_Req, 1);
    chk("retrigger_id", EIC_I_Id, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
